trireg_share_pair: RTL and testbench

- Synchronous, cycle-based model of two capacitive storage nodes, A and B, joined by a controllable pass switch.
- Each node may be actively driven. When undriven, a node holds its last charge at its capacitance strength, and the charge decays to X after a programmable number of cycles.
- With the switch closed, the nodes share drive and charge. Among undriven nodes, the larger capacitance wins.
- The block sits downstream of the switch-level driver network and consumes its per-node enable and value. Its registered value and strength outputs feed the strength-aware display/compare logic.

---
 rtl/trireg_pkg.sv | 48 ++++
 rtl/trireg_node.sv | 78 +++++++
 rtl/trireg_share_pair.sv | 97 +++++++++
 tb/tb_trireg_share_pair.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/trireg_pkg.sv
// Shared types and helpers for the trireg charge-storage pair.
package trireg_pkg;

    typedef enum logic [1:0] {
        V0 = 2'd0,
        V1 = 2'd1,
        VX = 2'd2
    } val_e;

    typedef enum logic [1:0] {
        SZ_SMALL  = 2'd0,
        SZ_MEDIUM = 2'd1,
        SZ_LARGE  = 2'd2
    } sz_e;

    typedef enum logic [2:0] {
        STR_HIZ    = 3'd0,
        STR_SMALL  = 3'd1,
        STR_MEDIUM = 3'd2,
        STR_LARGE  = 3'd4,
        STR_STRONG = 3'd6
    } str_e;

    typedef enum logic [1:0] {
        ST_DRIVEN  = 2'd0,
        ST_CHARGED = 2'd1,
        ST_DECAYED = 2'd2
    } node_st_e;

    function automatic str_e size_to_str(input sz_e sz);
        case (sz)
            SZ_SMALL:  return STR_SMALL;
            SZ_MEDIUM: return STR_MEDIUM;
            SZ_LARGE:  return STR_LARGE;
            default:   return STR_HIZ;
        endcase
    endfunction

    // The illegal encoding 3 is treated as an unknown drive.
    function automatic val_e clean_val(input logic [1:0] v);
        case (v)
            2'd0:    return V0;
            2'd1:    return V1;
            default: return VX;
        endcase
    endfunction

endpackage

// File: rtl/trireg_node.sv
// One capacitive storage node: drive/charge/decay FSM with a saturating decay counter.
module trireg_node
    import trireg_pkg::*;
#(
    parameter sz_e         SIZE         = SZ_SMALL,
    parameter int unsigned DECAY_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic drive_i,
    input  val_e drive_val_i,
    input  logic share_i,
    input  val_e share_val_i,
    output val_e val_o,
    output str_e str_o,
    output logic decayed_o
);

    localparam int CNT_W = (DECAY_CYCLES < 2) ? 1 : $clog2(DECAY_CYCLES);
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'((DECAY_CYCLES == 0) ? 0 : DECAY_CYCLES - 1);

    node_st_e         state_q, state_d;
    val_e             val_q, val_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_DECAYED;
            val_q   <= VX;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        if (drive_i) begin
            state_d = ST_DRIVEN;
            val_d   = drive_val_i;
            cnt_d   = '0;
        end else if (share_i && (share_val_i != val_q)) begin
            // Shared X charge leaves the node holding decayed charge.
            state_d = (share_val_i == VX) ? ST_DECAYED : ST_CHARGED;
            val_d   = share_val_i;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_DRIVEN: begin
                    state_d = ST_CHARGED;
                    cnt_d   = '0;
                end
                ST_CHARGED: begin
                    if ((DECAY_CYCLES != 0) && (cnt_q == LAST)) begin
                        state_d = ST_DECAYED;
                        val_d   = VX;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_DECAYED;
                    val_d   = VX;
                end
            endcase
        end
    end

    assign val_o     = val_q;
    assign str_o     = (state_q == ST_DRIVEN) ? STR_STRONG : size_to_str(SIZE);
    assign decayed_o = (state_q == ST_DECAYED);

endmodule

// File: rtl/trireg_share_pair.sv
// Two trireg nodes joined by a pass switch: drive resolution and charge sharing.
module trireg_share_pair
    import trireg_pkg::*;
#(
    parameter sz_e         A_SIZE       = SZ_LARGE,
    parameter sz_e         B_SIZE       = SZ_SMALL,
    parameter int unsigned DECAY_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_drv_en,
    input  logic [1:0] a_drv_val,
    input  logic       b_drv_en,
    input  logic [1:0] b_drv_val,
    input  logic       sw_on,
    output logic [1:0] a_val,
    output logic [2:0] a_str,
    output logic [1:0] b_val,
    output logic [2:0] b_str,
    output logic       a_decayed,
    output logic       b_decayed
);

    val_e av_in, bv_in;
    val_e a_cur, b_cur;
    str_e a_str_w, b_str_w;
    logic a_eff, b_eff;
    val_e a_dv, b_dv;
    logic a_share, b_share;
    val_e a_share_val, b_share_val;

    assign av_in = clean_val(a_drv_val);
    assign bv_in = clean_val(b_drv_val);

    always_comb begin
        a_eff       = a_drv_en | (sw_on & b_drv_en);
        b_eff       = b_drv_en | (sw_on & a_drv_en);
        a_dv        = av_in;
        b_dv        = bv_in;
        a_share     = 1'b0;
        b_share     = 1'b0;
        a_share_val = VX;
        b_share_val = VX;
        if (sw_on) begin
            if (a_drv_en && b_drv_en) begin
                a_dv = ((av_in == bv_in) && (av_in != VX)) ? av_in : VX;
                b_dv = a_dv;
            end else if (a_drv_en) begin
                b_dv = av_in;
            end else if (b_drv_en) begin
                a_dv = bv_in;
            end else begin
                // Undriven sharing: larger capacitance overrides the smaller one.
                if (A_SIZE > B_SIZE) begin
                    b_share     = 1'b1;
                    b_share_val = a_cur;
                end else if (B_SIZE > A_SIZE) begin
                    a_share     = 1'b1;
                    a_share_val = b_cur;
                end else if (a_cur != b_cur) begin
                    a_share = 1'b1;
                    b_share = 1'b1;
                end
            end
        end
    end

    trireg_node #(.SIZE(A_SIZE), .DECAY_CYCLES(DECAY_CYCLES)) u_node_a (
        .clk        (clk),
        .rst        (rst),
        .drive_i    (a_eff),
        .drive_val_i(a_dv),
        .share_i    (a_share),
        .share_val_i(a_share_val),
        .val_o      (a_cur),
        .str_o      (a_str_w),
        .decayed_o  (a_decayed)
    );

    trireg_node #(.SIZE(B_SIZE), .DECAY_CYCLES(DECAY_CYCLES)) u_node_b (
        .clk        (clk),
        .rst        (rst),
        .drive_i    (b_eff),
        .drive_val_i(b_dv),
        .share_i    (b_share),
        .share_val_i(b_share_val),
        .val_o      (b_cur),
        .str_o      (b_str_w),
        .decayed_o  (b_decayed)
    );

    assign a_val = a_cur;
    assign b_val = b_cur;
    assign a_str = a_str_w;
    assign b_str = b_str_w;

endmodule

// File: tb/tb_trireg_share_pair.sv
// Directed scoreboard bench for trireg_share_pair (A large, B small, 16-cycle decay).
module tb_trireg_share_pair;
    import trireg_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_drv_en, b_drv_en, sw_on;
    logic [1:0] a_drv_val, b_drv_val;
    logic [1:0] a_val, b_val;
    logic [2:0] a_str, b_str;
    logic       a_decayed, b_decayed;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [1:0] av;
        logic [2:0] as;
        logic [1:0] bv;
        logic [2:0] bs;
        logic       ad;
        logic       bd;
    } exp_t;

    exp_t sb[$];

    trireg_share_pair #(.A_SIZE(SZ_LARGE), .B_SIZE(SZ_SMALL), .DECAY_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_drv_en (a_drv_en),
        .a_drv_val(a_drv_val),
        .b_drv_en (b_drv_en),
        .b_drv_val(b_drv_val),
        .sw_on    (sw_on),
        .a_val    (a_val),
        .a_str    (a_str),
        .b_val    (b_val),
        .b_str    (b_str),
        .a_decayed(a_decayed),
        .b_decayed(b_decayed)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic aen, input logic [1:0] av,
                          input logic ben, input logic [1:0] bv, input logic sw);
        a_drv_en  = aen;
        a_drv_val = av;
        b_drv_en  = ben;
        b_drv_val = bv;
        sw_on     = sw;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] av, input logic [2:0] as,
                              input logic [1:0] bv, input logic [2:0] bs,
                              input logic ad, input logic bd);
        exp_t e;
        e.tag = tag; e.av = av; e.as = as; e.bv = bv; e.bs = bs; e.ad = ad; e.bd = bd;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input string fld, input logic [3:0] obs,
                       input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, expv);
        end
    endtask

    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "a_val", {2'b0, a_val}, {2'b0, e.av});
            chk(e.tag, "a_str", {1'b0, a_str}, {1'b0, e.as});
            chk(e.tag, "b_val", {2'b0, b_val}, {2'b0, e.bv});
            chk(e.tag, "b_str", {1'b0, b_str}, {1'b0, e.bs});
            chk(e.tag, "a_decayed", {3'b0, a_decayed}, {3'b0, e.ad});
            chk(e.tag, "b_decayed", {3'b0, b_decayed}, {3'b0, e.bd});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, V0, 1'b0, V0, 1'b0);
        #12;
        expect_out("reset", VX, STR_LARGE, VX, STR_SMALL, 1'b1, 1'b1);
        check_now();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A drives V1 through the closed switch, then releases.
        set_in(1'b1, V1, 1'b0, V0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            expect_out("a_drive_sw", V1, STR_STRONG, V1, STR_STRONG, 1'b0, 1'b0);
            step();
        end
        set_in(1'b0, V0, 1'b0, V0, 1'b1);
        expect_out("release", V1, STR_LARGE, V1, STR_SMALL, 1'b0, 1'b0);
        step();

        // Independent hold: 15 edges holding, decay on the 16th.
        set_in(1'b0, V0, 1'b0, V0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            expect_out("hold", V1, STR_LARGE, V1, STR_SMALL, 1'b0, 1'b0);
            step();
        end
        expect_out("decay16", VX, STR_LARGE, VX, STR_SMALL, 1'b1, 1'b1);
        step();

        // A charged V0, B charged V1; a one-edge share restarts B's counter.
        set_in(1'b1, V0, 1'b1, V1, 1'b0);
        expect_out("drive_indep", V0, STR_STRONG, V1, STR_STRONG, 1'b0, 1'b0);
        step();
        set_in(1'b0, V0, 1'b0, V0, 1'b0);
        for (int e = 0; e <= 4; e++) begin
            expect_out("charged_ab", V0, STR_LARGE, V1, STR_SMALL, 1'b0, 1'b0);
            step();
        end
        sw_on = 1'b1;
        expect_out("share", V0, STR_LARGE, V0, STR_SMALL, 1'b0, 1'b0);
        step();
        sw_on = 1'b0;
        for (int e = 6; e <= 21; e++) begin
            expect_out("post_share",
                       (e >= 16) ? VX : V0, STR_LARGE,
                       (e >= 21) ? VX : V0, STR_SMALL,
                       (e >= 16), (e >= 21));
            step();
        end

        // Drive resolution through the switch.
        set_in(1'b1, V0, 1'b1, V1, 1'b1);
        expect_out("conflict", VX, STR_STRONG, VX, STR_STRONG, 1'b0, 1'b0);
        step();
        sw_on = 1'b0;
        expect_out("sw_open", V0, STR_STRONG, V1, STR_STRONG, 1'b0, 1'b0);
        step();
        set_in(1'b1, V1, 1'b1, V1, 1'b1);
        expect_out("agree", V1, STR_STRONG, V1, STR_STRONG, 1'b0, 1'b0);
        step();
        set_in(1'b0, V1, 1'b1, V0, 1'b1);
        expect_out("b_only", V0, STR_STRONG, V0, STR_STRONG, 1'b0, 1'b0);
        step();
        set_in(1'b1, VX, 1'b1, VX, 1'b1);
        expect_out("both_x", VX, STR_STRONG, VX, STR_STRONG, 1'b0, 1'b0);
        step();

        // Async reset in the middle of a charged hold (counter = 7).
        set_in(1'b1, V1, 1'b1, V1, 1'b0);
        expect_out("pre_hold", V1, STR_STRONG, V1, STR_STRONG, 1'b0, 1'b0);
        step();
        set_in(1'b0, V0, 1'b0, V0, 1'b0);
        for (int e = 0; e <= 7; e++) begin
            expect_out("mid_hold", V1, STR_LARGE, V1, STR_SMALL, 1'b0, 1'b0);
            step();
        end
        #3;
        rst = 1'b1;
        #1;
        expect_out("async_rst", VX, STR_LARGE, VX, STR_SMALL, 1'b1, 1'b1);
        check_now();
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(1'b1, V1, 1'b0, V0, 1'b0);
        expect_out("resume", V1, STR_STRONG, VX, STR_SMALL, 1'b0, 1'b1);
        step();
        set_in(1'b0, V0, 1'b0, V0, 1'b0);
        expect_out("a_charged", V1, STR_LARGE, VX, STR_SMALL, 1'b0, 1'b1);
        step();
        sw_on = 1'b1;
        expect_out("revive_b", V1, STR_LARGE, V1, STR_SMALL, 1'b0, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
